// File: rtl/hough_pkg.sv
// Shared definitions for the Hough transform result path.
// Holds the packet sync byte, the number of forwarded line slots,
// the packer state encoding and the per-line record type.
package hough_pkg;

    localparam int         HOUGH_MAX_LINES = 4;
    localparam logic [7:0] HOUGH_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_CNT,
        ST_LINE,
        ST_CSUM,
        ST_FIN
    } pack_state_t;

    typedef struct packed {
        logic [7:0] rho;
        logic [7:0] theta;
        logic [7:0] votes;
    } line_rec_t;

    // Pick one byte of a line record: 0 = rho, 1 = theta, 2 = votes.
    function automatic logic [7:0] rec_field(input line_rec_t rec, input logic [1:0] idx);
        case (idx)
            2'd0:    return rec.rho;
            2'd1:    return rec.theta;
            default: return rec.votes;
        endcase
    endfunction

endpackage

// File: rtl/hough_result_packer.sv
// Hough result packer: snapshots the Hough core's results on its done
// pulse and streams them as a framed byte packet on a valid/ready link:
//   SYNC, n, {rho, theta, votes} x n, [checksum]
// Optional checksum byte is enabled with `define HOUGH_PKT_CHECKSUM_EN
// (modulo-256 sum of every byte after SYNC).
module hough_result_packer
    import hough_pkg::*;
#(
    parameter int         MAX_LINES = HOUGH_MAX_LINES,
    parameter logic [7:0] SYNC_BYTE = HOUGH_SYNC_BYTE
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       done,
    input  logic [7:0] num_lines,
    input  logic [7:0] line_rho_0,
    input  logic [7:0] line_rho_1,
    input  logic [7:0] line_rho_2,
    input  logic [7:0] line_rho_3,
    input  logic [7:0] line_theta_0,
    input  logic [7:0] line_theta_1,
    input  logic [7:0] line_theta_2,
    input  logic [7:0] line_theta_3,
    input  logic [7:0] line_votes_0,
    input  logic [7:0] line_votes_1,
    input  logic [7:0] line_votes_2,
    input  logic [7:0] line_votes_3,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic       pkt_done,
    output logic       overrun
);

    localparam logic [7:0] MAX_N = 8'(MAX_LINES);

    pack_state_t state;
    line_rec_t   snap [4];
    line_rec_t   in_rec [4];
    logic [7:0]  line_cnt;
    logic [1:0]  field_idx;
    logic [1:0]  line_idx;
    logic        capture;
    logic        xfer;
    logic        last_line;
    logic [7:0]  tail_data;

    assign in_rec[0] = '{rho: line_rho_0, theta: line_theta_0, votes: line_votes_0};
    assign in_rec[1] = '{rho: line_rho_1, theta: line_theta_1, votes: line_votes_1};
    assign in_rec[2] = '{rho: line_rho_2, theta: line_theta_2, votes: line_votes_2};
    assign in_rec[3] = '{rho: line_rho_3, theta: line_theta_3, votes: line_votes_3};

    // FIN already reports not-busy, so a done there starts the next packet.
    assign capture   = done && ((state == ST_IDLE) || (state == ST_FIN));
    assign xfer      = tx_valid && tx_ready;
    assign last_line = ({6'd0, line_idx} == (line_cnt - 8'd1));

`ifdef HOUGH_PKT_CHECKSUM_EN
    // After the last count/line byte the packet continues with the checksum.
    localparam pack_state_t TAIL_STATE = ST_CSUM;
    localparam logic        TAIL_VALID = 1'b1;
    localparam logic        TAIL_DONE  = 1'b0;

    logic [7:0] csum_acc;

    // The byte being accepted right now is folded in on the fly.
    assign tail_data = csum_acc + tx_data;

    // Running sum of every byte accepted after SYNC; cleared on capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_acc <= 8'd0;
        end else if (capture) begin
            csum_acc <= 8'd0;
        end else if (xfer && (state != ST_HDR)) begin
            csum_acc <= csum_acc + tx_data;
        end
    end
`else
    // After the last count/line byte the packet is complete.
    localparam pack_state_t TAIL_STATE = ST_FIN;
    localparam logic        TAIL_VALID = 1'b0;
    localparam logic        TAIL_DONE  = 1'b1;

    assign tail_data = tx_data;
`endif

    // Snapshot of count and line slots, taken only when a packet starts.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            line_cnt <= 8'd0;
            // NOTE: this small array lives in flops, not RAM, so it can be reset; the zero state is observable.
            for (int i = 0; i < 4; i++) begin
                snap[i] <= '0;
            end
        end else if (capture) begin
            line_cnt <= (num_lines > MAX_N) ? MAX_N : num_lines;
            for (int i = 0; i < 4; i++) begin
                snap[i] <= in_rec[i];
            end
        end
    end

    // Packet sequencer with registered stream and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            tx_data   <= 8'd0;
            tx_valid  <= 1'b0;
            busy      <= 1'b0;
            pkt_done  <= 1'b0;
            overrun   <= 1'b0;
            field_idx <= 2'd0;
            line_idx  <= 2'd0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every branch sees pre-edge values.
            pkt_done <= 1'b0;
            overrun  <= done && !capture;

            case (state)
                ST_IDLE, ST_FIN: begin
                    state    <= ST_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                    if (capture) begin
                        state     <= ST_HDR;
                        tx_data   <= SYNC_BYTE;
                        tx_valid  <= 1'b1;
                        busy      <= 1'b1;
                        field_idx <= 2'd0;
                        line_idx  <= 2'd0;
                    end
                end

                ST_HDR: begin
                    if (xfer) begin
                        state   <= ST_CNT;
                        tx_data <= line_cnt;
                    end
                end

                ST_CNT: begin
                    if (xfer) begin
                        if (line_cnt != 8'd0) begin
                            state   <= ST_LINE;
                            tx_data <= snap[0].rho;
                        end else begin
                            state    <= TAIL_STATE;
                            tx_data  <= tail_data;
                            tx_valid <= TAIL_VALID;
                            busy     <= TAIL_VALID;
                            pkt_done <= TAIL_DONE;
                        end
                    end
                end

                ST_LINE: begin
                    if (xfer) begin
                        if (field_idx != 2'd2) begin
                            field_idx <= field_idx + 2'd1;
                            tx_data   <= rec_field(snap[line_idx], field_idx + 2'd1);
                        end else if (!last_line) begin
                            field_idx <= 2'd0;
                            line_idx  <= line_idx + 2'd1;
                            tx_data   <= snap[line_idx + 2'd1].rho;
                        end else begin
                            state    <= TAIL_STATE;
                            tx_data  <= tail_data;
                            tx_valid <= TAIL_VALID;
                            busy     <= TAIL_VALID;
                            pkt_done <= TAIL_DONE;
                        end
                    end
                end

`ifdef HOUGH_PKT_CHECKSUM_EN
                ST_CSUM: begin
                    if (xfer) begin
                        state    <= ST_FIN;
                        tx_valid <= 1'b0;
                        busy     <= 1'b0;
                        pkt_done <= 1'b1;
                    end
                end
`endif

                default: begin
                    state    <= ST_IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
